rnd_pool: RTL and testbench
===========================

Name: rnd_pool

Overview:
- Consumer end of the random-number generator interface.
- Captures each 32-bit word the generator presents with its one-cycle valid pulse and buffers it in a small FIFO.
- Serves buffered words to the RSA datapath (key/nonce/blinding-value requests) over a valid/ready handshake.
- Decouples the generator's fixed 33-cycle production rate from bursty RSA demand.

Parameters:
- DATA_W, 32, width of random word.
- DEPTH, 16, FIFO entries; power of two.
- ADDR_W, 4, log2(DEPTH).
- WARMUP, 2, number of initial generator words discarded after reset; 0..255.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- rnd_valid_in  input  1  one-cycle pulse; rnd_in is valid this cycle.
- rnd_in  input  DATA_W  random word from generator.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds an unread word.
- rd_data  output  DATA_W  oldest buffered word (first-word fall-through).
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- drop_cnt  output  8  saturating count of words lost because the FIFO was full.
- health_fail  output  1  sticky health-test failure flag.

Behaviour:
- Reset (sampled on the clk edge with rst=0):
  - State = WARM; warm-up counter = 0; read/write pointers = 0.
  - level = 0, rd_valid = 0, rd_data = 0, drop_cnt = 0, health_fail = 0, previous-word register = 0.
  - Reset mid-operation discards all buffered contents.
- FSM, two states:
  - WARM: each rnd_valid_in increments the warm-up counter; the word is not stored. When the counter reaches WARMUP-1 on a pulse, go to RUN. If WARMUP=0, reset exits directly to RUN on the first active cycle.
  - RUN: remains in RUN until reset.
- Push (RUN only): on rnd_valid_in=1, write rnd_in at the write pointer when level<DEPTH, or when level==DEPTH and a pop occurs the same cycle.
- Drop: otherwise the word is dropped and drop_cnt increments, saturating at 255.
- Pop: a pop occurs when rd_valid && rd_ready. rd_ready while rd_valid=0 is ignored.
- Outputs:
  - rd_valid = (level != 0), registered.
  - rd_data = mem[rd_ptr], registered; it changes only on the cycle after a pop or a push into an empty FIFO.
  - rd_data holds its last value when empty.
- Latency: a word pushed into an empty FIFO at edge N is presented with rd_valid=1 after edge N+1.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is tracked separately so the full/empty distinction is exact.

Optional Feature:
- Macro RND_HEALTH_CHECK_EN.
- Defined:
  - Repetition test: in RUN, an incoming word equal to the previous accepted-or-rejected word is not stored, does not count as a drop, and sets health_fail=1 (sticky until reset).
  - The previous-word register updates on every rnd_valid_in in RUN.
  - A word of all zeros is also rejected and sets health_fail.
- Not defined: no comparison logic; every word is eligible for push; health_fail is tied to 0.

Decomposition:
- Shared package rsa_rng_pkg:
  - Constants RND_W=32 and RND_POOL_DEPTH=16.
  - FSM state enum rnd_pool_state_t {WARM, RUN}.
  - Drop-counter width constant.
- One natural sub-module: rnd_pool_fifo, the synchronous single-clock FIFO holding the memory, pointers, level and registered FWFT output.
- rnd_pool keeps the FSM, drop counter and health logic.

Test Plan:
- Warm-up discard: WARMUP=2; reset, then pulses with 0x11, 0x22, 0x33 → first two discarded; rd_valid rises one cycle after the 0x33 edge with rd_data=0x33; level=1.
- Ordering: push 0x100..0x104 with rd_ready=0 → level=5; then hold rd_ready=1 → rd_data reads 0x100..0x104 on consecutive cycles, and rd_valid falls after the last.
- Full/overflow: rd_ready=0; push 18 distinct words → level=16, drop_cnt=2, and the first 16 words are read back in order.
- Push and pop same cycle at full: level=16, pulse 0xABC with rd_ready=1 → level stays 16, drop_cnt unchanged, and 0xABC is read out last.
- Reset mid-operation: level=7, assert rst for 1 cycle → level=0, rd_valid=0, drop_cnt=0, state WARM, and the next WARMUP words are discarded.
- RND_HEALTH_CHECK_EN: push 0x5A5A, 0x5A5A, 0x0 → only one entry stored; health_fail=1 and stays 1 after later distinct words; without the macro, level=3 and health_fail=0.

Source files
------------

// File: rtl/rsa_rng_pkg.sv
// Shared types and constants for the random-number consumer path (rnd_pool and its FIFO).
package rsa_rng_pkg;

    localparam int RND_W          = 32;
    localparam int RND_POOL_DEPTH = 16;
    localparam int DROP_CNT_W     = 8;
    localparam int WARM_CNT_W     = 8;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } rnd_pool_state_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rnd_pool_fifo.sv
// Single-clock FIFO with an exact occupancy count and a registered first-word-fall-through output.
module rnd_pool_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [LW-1:0]     level_after_pop;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              pop;

    assign pop = rd_valid_reg && rd_ready;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg + ADDR_W'(push);
        rd_ptr_next     = rd_ptr_reg + ADDR_W'(pop);
        level_after_pop = level_reg - LW'(pop);
        level_next      = level_after_pop + LW'(push);
    end

    // Memory has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The output stage only sees words already in memory before this edge,
    // so a push into an empty FIFO surfaces one cycle after it is written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            rd_valid_reg <= (level_after_pop != '0);
            if (level_after_pop != '0) begin
                rd_data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign level    = level_reg;
    assign full     = (level_reg == FULL_LEVEL);

endmodule

// File: rtl/rnd_pool.sv
// Random-word pool: warm-up discard, FIFO buffering, drop counting.
// Optional repetition/zero health test enabled by defining RND_HEALTH_CHECK_EN.
module rnd_pool
    import rsa_rng_pkg::*;
#(
    parameter int DATA_W = RND_W,
    parameter int DEPTH  = RND_POOL_DEPTH,
    parameter int ADDR_W = 4,
    parameter int WARMUP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rnd_valid_in,
    input  logic [DATA_W-1:0]     rnd_in,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [ADDR_W:0]       level,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  health_fail
);

    localparam logic [WARM_CNT_W-1:0] WARM_LAST =
        (WARMUP == 0) ? '0 : WARM_CNT_W'(WARMUP - 1);

    rnd_pool_state_t       state_reg;
    rnd_pool_state_t       state_next;
    logic [WARM_CNT_W-1:0] warm_cnt_reg;
    logic [WARM_CNT_W-1:0] warm_cnt_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic                  health_reject;
    logic                  push_req;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  pop;
    logic                  drop_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= WARM;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        case (state_reg)
            WARM: begin
                if (WARMUP == 0) begin
                    state_next = RUN;
                end else if (rnd_valid_in) begin
                    warm_cnt_next = warm_cnt_reg + WARM_CNT_W'(1);
                    if (warm_cnt_reg == WARM_LAST) begin
                        state_next = RUN;
                    end
                end
            end
            RUN:     state_next = RUN;
            default: state_next = WARM;
        endcase
    end

`ifdef RND_HEALTH_CHECK_EN
    logic [DATA_W-1:0] prev_reg;
    logic              health_fail_reg;

    assign health_reject = (rnd_in == prev_reg) || (rnd_in == '0);

    // Previous word tracks every RUN pulse, whether or not it was stored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_reg        <= '0;
            health_fail_reg <= 1'b0;
        end else if ((state_reg == RUN) && rnd_valid_in) begin
            prev_reg <= rnd_in;
            if (health_reject) begin
                health_fail_reg <= 1'b1;
            end
        end
    end

    assign health_fail = health_fail_reg;
`else
    assign health_reject = 1'b0;
    assign health_fail   = 1'b0;
`endif

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pop       = rd_valid && rd_ready;
    assign push_req  = (state_reg == RUN) && rnd_valid_in && !health_reject;
    assign fifo_push = push_req && (!fifo_full || pop);
    assign drop_hit  = push_req && !fifo_push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_reg <= '0;
        end else if (drop_hit) begin
            drop_cnt_reg <= sat_inc(drop_cnt_reg);
        end
    end

    assign drop_cnt = drop_cnt_reg;

    rnd_pool_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rnd_in),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .level     (level),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_rnd_pool.sv
// Directed and randomized bench for rnd_pool against a queue-based reference model.
module tb_rnd_pool;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int WARMUP = 2;
`ifdef RND_HEALTH_CHECK_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              rnd_valid_in;
    logic [DATA_W-1:0] rnd_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   level;
    logic [7:0]        drop_cnt;
    logic              health_fail;

    int total;
    int bad;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_vis;
    logic [31:0] m_data;
    int          m_drop;
    bit          m_run;
    int          m_warm;
    logic [31:0] m_prev;
    bit          m_health;

    rnd_pool #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WARMUP (WARMUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rnd_valid_in (rnd_valid_in),
        .rnd_in       (rnd_in),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .drop_cnt     (drop_cnt),
        .health_fail  (health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, model update, and output comparison.
    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit rdy);
        bit had;
        bit rej;
        rst          = r;
        rnd_valid_in = v;
        rnd_in       = d;
        rd_ready     = rdy;
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_vis    = 1'b0;
            m_data   = '0;
            m_drop   = 0;
            m_run    = 1'b0;
            m_warm   = 0;
            m_prev   = '0;
            m_health = 1'b0;
        end else begin
            if (m_vis && rdy) void'(mq.pop_front());
            had = (mq.size() != 0);
            if (!m_run) begin
                if (WARMUP == 0) m_run = 1'b1;
                else if (v) begin
                    m_warm++;
                    if (m_warm == WARMUP) m_run = 1'b1;
                end
            end else if (v) begin
                rej    = HEALTH && ((d == m_prev) || (d == 32'd0));
                m_prev = d;
                if (rej) m_health = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(d);
                else if (m_drop < 255) m_drop++;
            end
            m_vis = had;
            if (had) m_data = mq[0];
        end
        #1;
        $display("step rst=%0b vld=%0b in=%h rdy=%0b -> rd_valid=%0b rd_data=%h level=%0d drop=%0d hf=%0b",
                 r, v, d, rdy, rd_valid, rd_data, level, drop_cnt, health_fail);
        chk("rd_valid", 32'(rd_valid), 32'(m_vis));
        chk("rd_data", rd_data, m_data);
        chk("level", 32'(level), 32'(mq.size()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("health_fail", 32'(health_fail), 32'(m_health));
        rnd_valid_in = 1'b0;
    endtask

    initial begin
        logic [31:0] last_sent;
        logic [31:0] w;
        bit          v;
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        rnd_valid_in = 1'b0;
        rnd_in       = '0;
        rd_ready     = 1'b0;
        last_sent    = '0;

        // Reset state
        step(0, 0, 0, 0);
        step(0, 1, 32'h55, 1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", rd_data, 32'd0);

        // Warm-up discard
        step(1, 1, 32'h11, 0);
        step(1, 0, 0, 0);
        step(1, 1, 32'h22, 0);
        chk("warm_empty", 32'(level), 32'd0);
        step(1, 1, 32'h33, 0);
        chk("warm_lat_valid", 32'(rd_valid), 32'd0);
        step(1, 0, 0, 0);
        chk("warm_valid", 32'(rd_valid), 32'd1);
        chk("warm_data", rd_data, 32'h33);
        chk("warm_level", 32'(level), 32'd1);
        step(1, 0, 0, 1);

        // Ordering
        for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + 32'(i), 0);
        chk("ord_level", 32'(level), 32'd5);
        chk("ord_head", rd_data, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 0, 1);
            if (k < 5) chk("ord_data", rd_data, 32'h100 + 32'(k));
        end
        chk("ord_valid_fall", 32'(rd_valid), 32'd0);

        // Full / overflow, then push+pop at full
        for (int i = 0; i < 18; i++) step(1, 1, 32'h200 + 32'(i), 0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_drop", 32'(drop_cnt), 32'd2);
        chk("full_head", rd_data, 32'h200);
        step(1, 1, 32'hABC, 1);
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_drop", 32'(drop_cnt), 32'd2);
        for (int k = 0; k < 16; k++) step(1, 0, 0, 1);
        chk("pp_last", rd_data, 32'hABC);
        chk("pp_empty", 32'(rd_valid), 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 16 + 260; i++) step(1, 1, 32'h1000 + 32'(i), 0);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        for (int k = 0; k < 17; k++) step(1, 0, 0, 1);

        // Randomized traffic, including repeats and zeros
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       w = last_sent;
                1:       w = 32'd0;
                default: w = $urandom;
            endcase
            v = ($urandom_range(0, 2) == 0);
            if (v) last_sent = w;
            step(1, v, w, 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation
        step(0, 0, 0, 0);
        step(1, 1, 32'h61, 0);
        step(1, 1, 32'h62, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 32'h300 + 32'(i), 0);
        chk("mid_level", 32'(level), 32'd7);
        step(0, 0, 0, 0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        step(1, 1, 32'h71, 0);
        step(1, 1, 32'h72, 0);
        chk("mid_warm_level", 32'(level), 32'd0);
        step(1, 1, 32'h73, 0);
        chk("mid_run_level", 32'(level), 32'd1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        // Health test
        step(1, 1, 32'h5A5A, 0);
        step(1, 1, 32'h5A5A, 0);
        step(1, 1, 32'h0, 0);
        chk("hc_level", 32'(level), HEALTH ? 32'd1 : 32'd3);
        chk("hc_flag", 32'(health_fail), 32'(HEALTH));
        step(1, 1, 32'h1234, 0);
        step(1, 1, 32'h5678, 0);
        chk("hc_sticky", 32'(health_fail), 32'(HEALTH));
        for (int k = 0; k < 6; k++) step(1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
